// File: rtl/rsa4_pkg.sv
// Shared types and constants for the 4-bit RSA encrypt engine.
// Holds the FSM state encoding and the timing constants the engine and its bench agree on.
package rsa4_pkg;

  localparam int W             = 4;
  localparam int REDUCE_CYCLES = 9;   // 1 load + 8 shift-subtract steps
  localparam int MAX_LATENCY   = 80;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    PRERED,
    MULR,
    REDR,
    MULB,
    REDB,
    NEXT,
    FIN
  } state_t;

endpackage

// File: rtl/mod_reduce_8by4.sv
// Restoring shift-subtract remainder of an 8-bit dividend by a 4-bit divisor; 9 cycles from start.
// No backpressure: start reloads unconditionally, done is valid for one cycle alongside the final rem.
module mod_reduce_8by4
  import rsa4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [3:0] rem,
  output logic       done
);

  logic [3:0] acc;
  logic [3:0] dvs;
  logic [7:0] sh;
  logic [2:0] cnt;
  logic       active;
  logic [4:0] trial;
  logic [4:0] diff;

  // acc < divisor always holds, so trial < 2*divisor and bit 4 of the
  // 5-bit difference is exactly the borrow (trial < divisor).
  assign trial = {acc, sh[7]};
  assign diff  = trial - {1'b0, dvs};
  assign rem   = diff[4] ? trial[3:0] : diff[3:0];

  // Flagged during the last step so the caller captures rem on the same edge.
  assign done  = active && (cnt == 3'(REDUCE_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      dvs    <= '0;
      sh     <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      dvs    <= divisor;
      sh     <= dividend;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc <= rem;
      sh  <= {sh[6:0], 1'b0};
      cnt <= cnt + 3'd1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/rsa4_encrypt_seq.sv
// Sequential cipher = msg^exp mod modn by right-to-left square-and-multiply; done within 80 cycles of accept.
// ENC is only sampled in IDLE; requests while busy are dropped, not queued.
module rsa4_encrypt_seq
  import rsa4_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ENC,
  input  logic [W-1:0] msg,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] modn,
  output logic [W-1:0] cipher,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int             IW   = $clog2(W);
  localparam logic [IW-1:0]  LAST = IW'(W - 1);

  state_t          state, state_n;
  logic [W-1:0]    m_r, e_r, n_r;
  logic [W-1:0]    base, result;
  logic [IW-1:0]   idx;
  logic [W-1:0]    mul_a, mul_b;
  logic [2*W-1:0]  prod;
  logic            red_start, red_done;
  logic [W-1:0]    red_rem;

  assign prod = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
  assign busy = (state != IDLE) && (state != FIN);

  mod_reduce_8by4 u_reduce (
    .clk      (clk),
    .rst      (rst),
    .start    (red_start),
    .dividend (prod),
    .divisor  (n_r),
    .rem      (red_rem),
    .done     (red_done)
  );

  always_comb begin
    state_n   = state;
    red_start = 1'b0;
    mul_a     = base;
    mul_b     = base;
    case (state)
      IDLE:   if (ENC) state_n = CHECK;
      CHECK: begin
        // Pre-reduction reuses the multiplier as msg*1.
        mul_a = m_r;
        mul_b = W'(1);
        if (n_r < W'(2)) begin
          state_n = FIN;
        end else begin
          red_start = 1'b1;
          state_n   = PRERED;
        end
      end
      PRERED: if (red_done) state_n = MULR;
      MULR: begin
        mul_a = result;
        if (e_r[idx]) begin
          red_start = 1'b1;
          state_n   = REDR;
        end else begin
          state_n = MULB;
        end
      end
      REDR:   if (red_done) state_n = MULB;
      MULB: begin
        if (idx == LAST) begin
          state_n = NEXT;
        end else begin
          red_start = 1'b1;
          state_n   = REDB;
        end
      end
      REDB:   if (red_done) state_n = NEXT;
      NEXT:   state_n = (idx == LAST) ? FIN : MULR;
      FIN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      m_r    <= '0;
      e_r    <= '0;
      n_r    <= '0;
      base   <= '0;
      result <= '0;
      idx    <= '0;
      cipher <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state_n == FIN);
      case (state)
        IDLE: if (ENC) begin
          m_r <= msg;
          e_r <= exp;
          n_r <= modn;
          err <= 1'b0;
        end
        CHECK: if (state_n == FIN) begin
          err    <= 1'b1;
          cipher <= '0;
        end
        PRERED: if (red_done) begin
          base   <= red_rem;
          result <= W'(1);
          idx    <= '0;
        end
        REDR: if (red_done) result <= red_rem;
        REDB: if (red_done) base <= red_rem;
        NEXT: begin
          if (idx == LAST) cipher <= result;
          else             idx    <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa4_encrypt_seq.sv
// Directed bench for rsa4_encrypt_seq with hand-computed ciphers, handshake and abort cases.
module tb_rsa4_encrypt_seq;
  import rsa4_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc = 1'b0;
  logic [3:0] msg_in = '0;
  logic [3:0] e_in = '0;
  logic [3:0] n_in = '0;
  logic [3:0] cipher;
  logic       busy, done, err;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  rsa4_encrypt_seq #(.W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .ENC    (enc),
    .msg    (msg_in),
    .exp    (e_in),
    .modn   (n_in),
    .cipher (cipher),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  task automatic check(input string tag, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
  endtask

  task automatic start_job(input int m, input int e, input int n);
    @(negedge clk);
    msg_in = 4'(m);
    e_in   = 4'(e);
    n_in   = 4'(n);
    enc    = 1'b1;
    @(negedge clk);
    enc    = 1'b0;
  endtask

  task automatic wait_done(input string tag, output bit seen);
    seen = 1'b0;
    for (int c = 1; c <= MAX_LATENCY && !seen; c++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, " done_in_bound"}, int'(seen), 1);
  endtask

  task automatic run_job(input string tag, input int m, input int e, input int n,
                         input int want_c, input int want_err);
    bit seen;
    start_job(m, e, n);
    check({tag, " busy"}, int'(busy), 1);
    wait_done(tag, seen);
    if (seen) begin
      check({tag, " cipher"}, int'(cipher), want_c);
      check({tag, " err"}, int'(err), want_err);
      @(negedge clk);
      check({tag, " done_width"}, int'(done), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    bit seen;
    int hm[3] = '{9, 0, 2};
    int he[3] = '{0, 7, 3};
    int hn[3] = '{11, 13, 15};
    int hc[3] = '{1, 0, 8};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset cipher", int'(cipher), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset err", int'(err), 0);
    rst = 1'b0;

    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("idle no_done", pulses, 0);

    run_job("textbook",    7, 3, 15, 13, 0);
    run_job("textbook_m2", 2, 3, 15,  8, 0);
    run_job("n14_e5",      3, 5, 14,  5, 0);
    run_job("e0",          9, 0, 11,  1, 0);
    run_job("m0",          0, 7, 13,  0, 0);
    run_job("prered",      9, 2,  5,  1, 0);
    run_job("e15_worst",   2, 15, 13, 8, 0);
    run_job("n2",          3, 1,  2,  1, 0);
    run_job("n1",          5, 3,  1,  0, 1);
    run_job("n0",          6, 2,  0,  0, 1);
    run_job("recover",     7, 3, 15, 13, 0);

    // Second request mid-job must be dropped.
    start_job(7, 3, 15);
    repeat (4) @(negedge clk);
    msg_in = 4'd2;
    e_in   = 4'd1;
    n_in   = 4'd13;
    enc    = 1'b1;
    @(negedge clk);
    enc    = 1'b0;
    check("ignore busy", int'(busy), 1);
    wait_done("ignore", seen);
    if (seen) check("ignore cipher", int'(cipher), 13);

    // ENC held: each done is followed by an immediate restart with new operands.
    @(negedge clk);
    msg_in = 4'(hm[0]);
    e_in   = 4'(he[0]);
    n_in   = 4'(hn[0]);
    enc    = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_done("held", seen);
      if (seen) begin
        check("held cipher", int'(cipher), hc[j]);
        if (j < 2) begin
          msg_in = 4'(hm[j+1]);
          e_in   = 4'(he[j+1]);
          n_in   = 4'(hn[j+1]);
        end else begin
          enc = 1'b0;
        end
        @(negedge clk);
        check("held done_width", int'(done), 0);
      end
    end
    enc = 1'b0;

    // Abort 10 cycles after accept.
    start_job(7, 3, 15);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort cipher", int'(cipher), 0);
    check("abort err", int'(err), 0);
    rst = 1'b0;
    pulses = 0;
    repeat (90) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort no_done", pulses, 0);
    run_job("after_abort", 2, 3, 15, 8, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rsa4_encrypt_seq.md
Name: rsa4_encrypt_seq

Overview:
- Sequential 4-bit RSA encryption engine: computes cipher = msg^exp mod modn using right-to-left square-and-multiply.
- Each modular multiply is reduced by a shift-subtract remainder unit.
- Encrypt-side counterpart to the decode-path arithmetic. Sits ahead of the channel/display logic and is started by the ENC command, in the same way DEC gates decode arithmetic.

Parameters:
- W, 4, operand width for msg/exp/modn/cipher (products are 2*W bits; only W=4 is verified).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- ENC  input  1  start request; sampled only in IDLE
- msg  input  4  plaintext M, captured on accepted ENC
- exp  input  4  public exponent E, captured on accepted ENC
- modn  input  4  modulus N, captured on accepted ENC
- cipher  output  4  result C; holds its value until the next accepted ENC
- busy  output  1  high from the cycle after accept until done
- done  output  1  one-cycle pulse when cipher/err are valid
- err  output  1  set with done when N<2; cleared on next accept

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: cipher=0, busy=0, done=0, err=0, FSM=IDLE, all internal registers 0.
- rst asserted mid-operation aborts the computation on the next edge. No done pulse is produced for the aborted job.
- Accept rule: ENC=1 while in IDLE captures msg/exp/modn and clears err.
  - busy rises on the next cycle.
  - ENC while busy is ignored, with no queuing.
  - ENC held high continuously restarts immediately after each done.
- FSM states: IDLE, CHECK, PRERED, MULR, REDR, MULB, REDB, NEXT, FIN.
  - CHECK: if N<2, go to FIN with err=1 and cipher=0. Otherwise go to PRERED.
  - PRERED: base = M mod N (the reduce unit handles M>=N); result = 1; bit index i = 0.
  - MULR: if E[i]=1, prod = result*base (8-bit), start reduce, go to REDR. Otherwise go to MULB.
  - REDR: wait for reduce done, then result = remainder.
  - MULB: if i=3, skip to NEXT. Otherwise prod = base*base, start reduce, go to REDB.
  - REDB: wait for reduce done, then base = remainder.
  - NEXT: if i=3, go to FIN. Otherwise i=i+1 and go to MULR.
  - FIN: cipher <= result (or 0 on err), done=1 for exactly one cycle, busy=0, return to IDLE.
- Arithmetic:
  - Products are 8 bits unsigned, zero-extended 4x4.
  - The remainder is always < N.
  - No overflow is possible because both operands are < N <= 15.
- Boundaries:
  - E=0 gives C=1 (for N>=2).
  - M=0 with E>0 gives C=0.
  - M>=N is legal and reduced first.
  - N=0 or N=1 gives err=1, cipher=0.
- Latency:
  - Data-dependent; the bench must use done.
  - Bound: done asserts no later than 80 cycles after accept.
  - Each reduce takes exactly 9 cycles (1 load + 8 shift-subtract).

Decomposition:
- Shared package rsa4_pkg:
  - W=4
  - FSM state enum
  - REDUCE_CYCLES=9
  - MAX_LATENCY=80
- Sub-module mod_reduce_8by4: sequential restoring shift-subtract remainder of 8-bit dividend by 4-bit divisor.
  - Ports: clk, rst, start, dividend[7:0], divisor[3:0], rem[3:0], done.
  - Each step uses a 5-bit compare/subtract with borrow.
- The top level holds the FSM, operand registers, and the 4x4 multiplier.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> cipher=0, busy=0, done=0, err=0; ENC=0 for 20 cycles -> no done.
- Textbook key: N=15, E=3, M=7, ENC pulse -> single done within 80 cycles, cipher=13, err=0. Repeat with M=2 -> cipher=8.
- Exponent/operand edges:
  - N=14, E=5, M=3 -> cipher=5.
  - E=0, N=11, M=9 -> cipher=1.
  - M=0, E=7, N=13 -> cipher=0.
  - M=9, N=5, E=2 -> cipher=1 (pre-reduction).
- Invalid modulus: N=1 (and N=0), any M/E -> done with err=1, cipher=0. Next valid job (N=15, E=3, M=7) -> err cleared, cipher=13.
- Handshake:
  - ENC re-pulsed while busy with different operands -> ignored; result matches the first job.
  - ENC held high -> back-to-back jobs, one done per job, each done exactly 1 cycle wide.
- Reset mid-operation: assert rst 10 cycles after accept -> outputs return to reset values next edge, no done pulse. A fresh job (N=15, E=3, M=2) then completes with cipher=8.
